vga_timing_rx: RTL and testbench



---
 rtl/vga_timing_rx.sv | 199 +++++++++++++++++++
 tb/tb_vga_timing_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_rx.sv
// rtl/vga_timing_rx.sv - VGA sync receiver: recovers x/y position and locks onto HS/VS timing
//
// Purpose: measures the incoming HS/VS period, tracks the recovered pixel
// position and declares lock after LOCK_FRAMES consecutive good frames.
//
// Ports:
//   clk       pixel clock
//   reset     asynchronous active-high reset
//   hs_n      horizontal sync input, active low
//   vs_n      vertical sync input, active low
//   x, y      recovered column / line (source position of the previous cycle)
//   active    locked and inside the visible area
//   locked    timing lock indicator
//   sync_err  one-cycle pulse when tracking or lock is lost
//   h_total   last measured HS-to-HS period in clocks
//   v_total   last measured number of HS falls between VS falls
module vga_timing_rx #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hs_n,
    input  logic       vs_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       locked,
    output logic       sync_err,
    output logic [9:0] h_total,
    output logic [9:0] v_total
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_SS    = H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_SS    = V_ACTIVE + V_FP;
    localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        LOCKED
    } state_t;

    state_t      state_q, state_d;
    logic        hs_q, vs_q;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [9:0]  h_total_q, h_total_d, v_total_q, v_total_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic        h_valid_q, h_valid_d;
    logic        frame_bad_q, frame_bad_d;
    logic        active_q, active_d;
    logic        locked_q, locked_d;
    logic        sync_err_q, sync_err_d;

    logic        hs_fall, vs_fall;
    logic [10:0] hcnt_inc;
    logic        h_bad, timeout, h_err, frame_good, to_search;

    assign hs_fall  = ~hs_n & hs_q;
    assign vs_fall  = ~vs_n & vs_q;
    assign hcnt_inc = {1'b0, hcnt_q} + 11'd1;

    // The first HS fall after (re)entering SEARCH only starts a measurement.
    assign h_bad      = hs_fall & h_valid_q & (hcnt_inc != 11'(H_TOTAL));
    // Fires once, on the cycle hcnt steps onto its saturation value.
    assign timeout    = ~hs_fall & (hcnt_q == 10'd1022);
    assign h_err      = h_bad | timeout;
    assign frame_good = (vcnt_q == 10'(V_TOTAL)) & ~frame_bad_q & ~h_err;

    // Position and measurement counters
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        h_total_d = h_total_q;
        v_total_d = v_total_q;

        if (vs_fall) begin
            x_d = 10'd0;
            y_d = 10'(V_SS);
        end else if (hs_fall) begin
            x_d = 10'(H_SS);
        end else if (x_q >= 10'(H_TOTAL - 1)) begin
            x_d = 10'd0;
            y_d = (y_q >= 10'(V_TOTAL - 1)) ? 10'd0 : y_q + 10'd1;
        end else begin
            x_d = x_q + 10'd1;
        end

        if (hs_fall) begin
            hcnt_d    = 10'd0;
            h_total_d = hcnt_inc[9:0];
        end else if (hcnt_q != 10'd1023) begin
            hcnt_d = hcnt_q + 10'd1;
        end

        if (vs_fall) begin
            vcnt_d    = 10'd0;
            v_total_d = vcnt_q;
        end else if (hs_fall && vcnt_q != 10'd1023) begin
            vcnt_d = vcnt_q + 10'd1;
        end
    end

    // Lock state machine
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_d    = TRACK;
                    good_cnt_d = 8'd0;
                end
            end
            TRACK: begin
                if (h_err || (vs_fall && !frame_good)) begin
                    state_d = SEARCH;
                end else if (vs_fall) begin
                    good_cnt_d = good_cnt_q + 8'd1;
                    if (good_cnt_q + 8'd1 >= LOCK_N) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (h_err || (vs_fall && !frame_good)) begin
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        to_search   = (state_q != SEARCH) && (state_d == SEARCH);
        h_valid_d   = to_search ? 1'b0 : (h_valid_q | hs_fall);
        frame_bad_d = vs_fall ? 1'b0 : (frame_bad_q | h_err);
        sync_err_d  = to_search;
        locked_d    = (state_d == LOCKED);
        active_d    = (state_d == LOCKED) && (x_d < 10'(H_ACTIVE)) && (y_d < 10'(V_ACTIVE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SEARCH;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            x_q         <= 10'd0;
            y_q         <= 10'd0;
            hcnt_q      <= 10'd0;
            vcnt_q      <= 10'd0;
            h_total_q   <= 10'd0;
            v_total_q   <= 10'd0;
            good_cnt_q  <= 8'd0;
            h_valid_q   <= 1'b0;
            frame_bad_q <= 1'b0;
            active_q    <= 1'b0;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hs_q        <= hs_n;
            vs_q        <= vs_n;
            x_q         <= x_d;
            y_q         <= y_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            h_total_q   <= h_total_d;
            v_total_q   <= v_total_d;
            good_cnt_q  <= good_cnt_d;
            h_valid_q   <= h_valid_d;
            frame_bad_q <= frame_bad_d;
            active_q    <= active_d;
            locked_q    <= locked_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign active   = active_q;
    assign locked   = locked_q;
    assign sync_err = sync_err_q;
    assign h_total  = h_total_q;
    assign v_total  = v_total_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb/tb_vga_timing_rx.sv - scoreboard testbench for vga_timing_rx on a reduced 25x19 raster
module tb_vga_timing_rx;

    localparam int HA = 16, HF = 2, HSY = 4, HB = 3;
    localparam int VA = 12, VF = 2, VSY = 2, VB = 3;
    localparam int LF = 2;
    localparam int HT = HA + HF + HSY + HB;   // 25
    localparam int HSS = HA + HF;             // 18
    localparam int VT = VA + VF + VSY + VB;   // 19
    localparam int VSS = VA + VF;             // 14
    localparam int K_RISE = 0, K_FALL = 1, K_ERR = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hs_n = 1'b1;
    logic       vs_n = 1'b1;
    logic [9:0] x, y, h_total, v_total;
    logic       active, locked, sync_err;

    vga_timing_rx #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .hs_n(hs_n), .vs_n(vs_n),
        .x(x), .y(y), .active(active), .locked(locked), .sync_err(sync_err),
        .h_total(h_total), .v_total(v_total)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int kind;} ev_t;
    typedef struct {int cyc; int x; int y; int act; int lk; int ht; int vt;} snap_t;

    ev_t   ev_q[$];
    snap_t snap_q[$];
    int    cyc = 0, n_checks = 0, n_fail = 0;
    int    sx = 0, sy = 0, nlines = VT, last_hs_cyc = 0;
    int    cur_x = 0, cur_y = 0;
    bit    skip_armed = 1'b0, hs_fall_now = 1'b0, vs_fall_now = 1'b0;
    logic  prev_locked = 1'b0;

    function automatic void check(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endfunction

    function automatic void push_ev(int c, int k);
        ev_t e;
        e.cyc = c;
        e.kind = k;
        ev_q.push_back(e);
    endfunction

    function automatic void push_snap(int c, int px, int py, int pa, int pl, int pht, int pvt);
        snap_t s;
        s.cyc = c; s.x = px; s.y = py; s.act = pa; s.lk = pl; s.ht = pht; s.vt = pvt;
        snap_q.push_back(s);
    endfunction

    function automatic void observe(int k);
        ev_t e;
        if (ev_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event kind=%0d at cyc %0d, expected none", k, cyc);
        end else begin
            e = ev_q.pop_front();
            check("event_kind", k, e.kind);
            check("event_cyc", cyc, e.cyc);
        end
    endfunction

    function automatic void check_snaps();
        snap_t s;
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            s = snap_q.pop_front();
            check("snap_cyc", cyc, s.cyc);
            if (s.x  >= 0) check("x", int'(x), s.x);
            if (s.y  >= 0) check("y", int'(y), s.y);
            if (s.act >= 0) check("active", int'(active), s.act);
            if (s.lk >= 0) check("locked", int'(locked), s.lk);
            if (s.ht >= 0) check("h_total", int'(h_total), s.ht);
            if (s.vt >= 0) check("v_total", int'(v_total), s.vt);
        end
    endfunction

    // Monitor: pops an expected event whenever the DUT shows one, and
    // compares cycle-stamped snapshots.
    always @(negedge clk) begin
        if (locked != prev_locked) observe(locked ? K_RISE : K_FALL);
        if (sync_err) observe(K_ERR);
        prev_locked <= locked;
        check_snaps();
    end

    task automatic step(input bit force_hi);
        logic hs_new, vs_new;
        @(posedge clk);
        #1;
        cyc++;
        hs_new = force_hi || !(sx >= HSS && sx < HSS + HSY);
        vs_new = force_hi || !(sy >= VSS && sy < VSS + VSY);
        hs_fall_now = hs_n && !hs_new;
        vs_fall_now = vs_n && !vs_new;
        hs_n = hs_new;
        vs_n = vs_new;
        if (hs_fall_now) last_hs_cyc = cyc;
        cur_x = sx;
        cur_y = sy;
        if (skip_armed && sy == 3 && sx == 5) begin
            sx = sx + 2;
            skip_armed = 1'b0;
        end else begin
            sx = sx + 1;
        end
        if (sx >= HT) begin
            sx = 0;
            sy = (sy + 1 >= nlines) ? 0 : sy + 1;
        end
    endtask

    // what: 0 = HS fall, 1 = VS fall
    task automatic wait_for(input int what, input string tag);
        int n = 0;
        bit hit;
        do begin
            step(1'b0);
            n++;
            hit = (what == 0) ? hs_fall_now : vs_fall_now;
        end while (!hit && n < 2000);
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s wait_timeout after %0d cycles", tag, n);
        end
    endtask

    task automatic do_reset(input bit was_locked);
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b1;
        hs_n = 1'b1;
        vs_n = 1'b1;
        if (was_locked) push_ev(cyc, K_FALL);
        push_snap(cyc, 0, 0, 0, 0, 0, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            cyc++;
            push_snap(cyc, 0, 0, 0, 0, 0, 0);
        end
        reset = 1'b0;
        sx = 0;
        sy = 0;
    endtask

    task automatic lock_from_start();
        sx = 0;
        sy = 0;
        nlines = VT;
        wait_for(1, "vs1");
        wait_for(1, "vs2");
        wait_for(1, "vs3");
        push_ev(cyc + 1, K_RISE);
        push_snap(cyc + 1, cur_x, cur_y, 0, 1, HT, VT);
        repeat (HT * VT) begin
            step(1'b0);
            push_snap(cyc + 1, cur_x, cur_y, (cur_x < HA && cur_y < VA) ? 1 : 0, 1, HT, VT);
        end
    endtask

    initial begin
        int n;
        int c;

        // Reset state and first lock from a clean source
        do_reset(1'b0);
        lock_from_start();

        // One 24-clock line while locked
        skip_armed = 1'b1;
        n = 0;
        while (skip_armed && n < 2000) begin
            step(1'b0);
            n++;
        end
        wait_for(0, "hs_after_skip");
        push_ev(cyc + 1, K_FALL);
        push_ev(cyc + 1, K_ERR);
        push_snap(cyc + 1, cur_x, cur_y, 0, 0, HT - 1, VT);
        wait_for(1, "relock_vs1");
        wait_for(1, "relock_vs2");
        wait_for(1, "relock_vs3");
        push_ev(cyc + 1, K_RISE);
        push_snap(cyc + 1, cur_x, cur_y, 0, 1, HT, VT);

        // Reset pulse while locked, then relock from scratch
        repeat (30) step(1'b0);
        do_reset(1'b1);
        lock_from_start();

        // Syncs stuck high while locked: timeout at hcnt=1023
        c = last_hs_cyc;
        push_snap(c + 1023, -1, -1, -1, 1, -1, -1);
        push_ev(c + 1024, K_FALL);
        push_ev(c + 1024, K_ERR);
        push_snap(c + 1024, -1, -1, 0, 0, -1, -1);
        repeat (1100) step(1'b1);
        do_reset(1'b0);

        // Short frames (VT-1 lines): never locks, error on each bad VS fall in TRACK
        nlines = VT - 1;
        wait_for(1, "short_vs1");
        wait_for(1, "short_vs2");
        push_ev(cyc + 1, K_ERR);
        push_snap(cyc + 1, cur_x, cur_y, 0, 0, -1, VT - 1);
        wait_for(1, "short_vs3");
        wait_for(1, "short_vs4");
        push_ev(cyc + 1, K_ERR);
        push_snap(cyc + 1, cur_x, cur_y, 0, 0, -1, VT - 1);
        wait_for(1, "short_vs5");
        repeat (50) step(1'b0);

        repeat (2) @(posedge clk);
        #6;
        check("pending_events", ev_q.size(), 0);
        check("pending_snaps", snap_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
